// File: rtl/fmcw_pkg.sv
// Shared constants and helpers for the FMCW range-processing chain.
// Holds the frame geometry, the bit-reverse helper and the magnitude-approximation shifts.
package fmcw_pkg;

  localparam int unsigned FFT_N   = 256;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned MAG_SH1 = 2;
  localparam int unsigned MAG_SH2 = 3;

  function automatic int unsigned log2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((v >> r) > 1) r++;
    return r;
  endfunction

  // Reverse the low nbits of idx: full 32-bit reverse, then realign to the bottom.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int unsigned nbits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[5'(i)] = idx[5'(31 - i)];
    return r >> (32 - nbits);
  endfunction

endpackage

// File: rtl/fft_mag_approx.sv
// Two-stage alpha-max/beta-min magnitude estimate with a side-band tag carried unmodified.
module fft_mag_approx
  import fmcw_pkg::*;
#(
  parameter int unsigned DW = DATA_W,
  parameter int unsigned TW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          en,
  input  logic [DW-1:0] re,
  input  logic [DW-1:0] im,
  input  logic [TW-1:0] tag,
  output logic          en_o,
  output logic [DW-1:0] mag,
  output logic [TW-1:0] tag_o
);

  localparam logic [DW-1:0] MAX_POS = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};

  logic [DW-1:0] w_ax, w_ay, w_mx, w_mn, w_mag;
  logic [DW-1:0] r_ax, r_ay;
  logic          r_en1;
  logic [TW-1:0] r_tag1;

  // The most negative input has no positive twin, so it saturates.
  always_comb begin
    w_ax = re;
    w_ay = im;
    if (re == MIN_NEG)  w_ax = MAX_POS;
    else if (re[DW-1])  w_ax = DW'(~re + DW'(1));
    if (im == MIN_NEG)  w_ay = MAX_POS;
    else if (im[DW-1])  w_ay = DW'(~im + DW'(1));
  end

  always_comb begin
    w_mx  = (r_ax >= r_ay) ? r_ax : r_ay;
    w_mn  = (r_ax >= r_ay) ? r_ay : r_ax;
    w_mag = w_mx + (w_mn >> MAG_SH1) + (w_mn >> MAG_SH2);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_en1  <= 1'b0;
      r_ax   <= '0;
      r_ay   <= '0;
      r_tag1 <= '0;
      en_o   <= 1'b0;
      mag    <= '0;
      tag_o  <= '0;
    end else begin
      r_en1  <= en;
      r_ax   <= w_ax;
      r_ay   <= w_ay;
      r_tag1 <= tag;
      en_o   <= r_en1;
      mag    <= w_mag;
      tag_o  <= r_tag1;
    end
  end

endmodule

// File: rtl/fft_peak_detect.sv
// Per-frame range-bin peak search on the bit-reversed FFT output stream.
// Input capture -> magnitude (2 stages) -> compare/update/emit.
module fft_peak_detect
  import fmcw_pkg::*;
#(
  parameter int unsigned N       = FFT_N,
  parameter int unsigned DW      = DATA_W,
  parameter int unsigned SKIP_DC = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 di_en,
  input  logic [DW-1:0]        di_re,
  input  logic [DW-1:0]        di_im,
  input  logic [DW-1:0]        thresh,
  output logic                 pk_valid,
  output logic [log2(N)-1:0]   pk_bin,
  output logic [DW-1:0]        pk_mag,
  output logic                 pk_found
);

  localparam int unsigned NN = log2(N);
  localparam int unsigned TW = NN + 2;
  localparam logic [NN-1:0] WIN_LO = NN'(SKIP_DC);
  localparam logic [NN-1:0] WIN_HI = NN'(N/2 - 1);

  logic [NN-1:0] r_cnt;
  logic          r_in_en;
  logic [DW-1:0] r_in_re, r_in_im;
  logic [TW-1:0] r_in_tag;

  logic [NN-1:0] w_bin_in;
  logic          w_win_in, w_last_in;

  logic          w_en3;
  logic [DW-1:0] w_mag3;
  logic [TW-1:0] w_tag3;
  logic [NN-1:0] w_bin3;
  logic          w_win3, w_last3, w_take, w_emit;
  logic [DW-1:0] w_res_mag;
  logic [NN-1:0] w_res_bin;

  logic [DW-1:0] r_best_mag;
  logic [NN-1:0] r_best_bin;
  logic          r_have;

  // Tag = {last-of-frame, in-window, natural bin}.
  always_comb begin
    w_bin_in  = NN'(bitrev(32'(r_cnt), NN));
    w_win_in  = (w_bin_in >= WIN_LO) && (w_bin_in <= WIN_HI);
    w_last_in = (r_cnt == NN'(N - 1));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_in_en  <= 1'b0;
      r_in_re  <= '0;
      r_in_im  <= '0;
      r_in_tag <= '0;
    end else begin
      r_in_en  <= di_en;
      r_in_re  <= di_re;
      r_in_im  <= di_im;
      r_in_tag <= {w_last_in, w_win_in, w_bin_in};
      if (di_en) r_cnt <= r_cnt + NN'(1);
    end
  end

  fft_mag_approx #(
    .DW (DW),
    .TW (TW)
  ) u_mag (
    .clock (clock),
    .reset (reset),
    .en    (r_in_en),
    .re    (r_in_re),
    .im    (r_in_im),
    .tag   (r_in_tag),
    .en_o  (w_en3),
    .mag   (w_mag3),
    .tag_o (w_tag3)
  );

  // Ties resolve to the lower bin regardless of arrival order.
  always_comb begin
    w_bin3    = w_tag3[NN-1:0];
    w_win3    = w_tag3[NN];
    w_last3   = w_tag3[NN+1];
    w_take    = w_en3 && w_win3 &&
                (!r_have || (w_mag3 > r_best_mag) ||
                 ((w_mag3 == r_best_mag) && (w_bin3 < r_best_bin)));
    w_res_mag = w_take ? w_mag3 : r_best_mag;
    w_res_bin = w_take ? w_bin3 : r_best_bin;
    w_emit    = w_en3 && w_last3;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_best_mag <= '0;
      r_best_bin <= '0;
      r_have     <= 1'b0;
      pk_valid   <= 1'b0;
      pk_bin     <= '0;
      pk_mag     <= '0;
      pk_found   <= 1'b0;
    end else begin
      pk_valid <= w_emit;
      if (w_emit) begin
        r_best_mag <= '0;
        r_best_bin <= '0;
        r_have     <= 1'b0;
        pk_bin     <= w_res_bin;
        pk_mag     <= w_res_mag;
        pk_found   <= (w_res_mag >= thresh);
      end else if (w_take) begin
        r_best_mag <= w_mag3;
        r_best_bin <= w_bin3;
        r_have     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed bench for fft_peak_detect: whole frames are streamed in bit-reversed order,
// expected peaks are queued at the last sample and checked when pk_valid pulses.
module tb_fft_peak_detect;

  logic        clock = 1'b0;
  logic        reset;
  logic        di_en;
  logic [15:0] di_re, di_im, thresh;
  logic        pk_valid;
  logic [7:0]  pk_bin;
  logic [15:0] pk_mag;
  logic        pk_found;

  typedef struct {
    int bin;
    int mag;
    int found;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   pulses = 0;
  int   fre[256];
  int   fim[256];

  fft_peak_detect dut (
    .clock    (clock),
    .reset    (reset),
    .di_en    (di_en),
    .di_re    (di_re),
    .di_im    (di_im),
    .thresh   (thresh),
    .pk_valid (pk_valid),
    .pk_bin   (pk_bin),
    .pk_mag   (pk_mag),
    .pk_found (pk_found)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int br8(input int k);
    int r;
    r = 0;
    for (int i = 0; i < 8; i++) if (((k >> i) & 1) != 0) r |= (1 << (7 - i));
    return r;
  endfunction

  task automatic clear_frame();
    for (int i = 0; i < 256; i++) begin
      fre[i] = 0;
      fim[i] = 0;
    end
  endtask

  task automatic idle(input int n);
    di_en = 1'b0;
    di_re = '0;
    di_im = '0;
    repeat (n) @(negedge clock);
  endtask

  // Streams one full frame; gaps never precede sample 0 so frames can abut.
  task automatic send_frame(input int gap_pct, input int eb, input int em, input int ef);
    exp_t x;
    for (int k = 0; k < 256; k++) begin
      if (k > 0 && $urandom_range(99) < gap_pct) begin
        di_en = 1'b0;
        repeat ($urandom_range(3, 1)) @(negedge clock);
      end
      di_en = 1'b1;
      di_re = 16'(fre[br8(k)]);
      di_im = 16'(fim[br8(k)]);
      @(negedge clock);
    end
    x.bin = eb;
    x.mag = em;
    x.found = ef;
    x.cyc = cyc + 3;
    sb.push_back(x);
  endtask

  always @(negedge clock) begin
    if (reset === 1'b0 && pk_valid === 1'b1) begin
      pulses++;
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("pk_bin", 32'(pk_bin), 32'(e.bin));
        check("pk_mag", 32'(pk_mag), 32'(e.mag));
        check("pk_found", 32'(pk_found), 32'(e.found));
        check("latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    reset = 1'b1;
    di_en = 1'b0;
    di_re = '0;
    di_im = '0;
    thresh = 16'd500;
    repeat (3) @(negedge clock);
    check("rst_valid", 32'(pk_valid), 32'd0);
    check("rst_bin", 32'(pk_bin), 32'd0);
    check("rst_mag", 32'(pk_mag), 32'd0);
    check("rst_found", 32'(pk_found), 32'd0);
    reset = 1'b0;
    idle(2);

    // single tone
    clear_frame();
    fre[10] = 1000;
    send_frame(0, 10, 1000, 1);
    idle(5);

    // magnitude arithmetic, including saturation of the most negative value
    clear_frame();
    fre[20] = -3000; fim[20] = 4000;
    send_frame(10, 20, 5125, 1);
    idle(5);
    clear_frame();
    fre[21] = -32768; fim[21] = -32768;
    send_frame(0, 21, 45053, 1);
    idle(5);

    // window exclusion: DC bins and negative-frequency bins ignored
    clear_frame();
    fre[0] = 30000; fre[1] = 30000; fre[200] = 30000; fre[50] = 100;
    send_frame(0, 50, 100, 0);
    idle(5);
    clear_frame();
    fre[2] = 650; fre[127] = 700; fre[128] = 900; fre[255] = 20000;
    send_frame(0, 127, 700, 1);
    idle(5);

    // ties go to the lowest bin whichever arrives first; below threshold still pulses
    thresh = 16'd2500;
    clear_frame();
    fre[30] = 2000; fre[12] = 2000;
    send_frame(0, 12, 2000, 0);
    idle(5);
    clear_frame();
    fre[40] = 2000; fre[24] = 2000;
    send_frame(0, 24, 2000, 0);
    idle(5);

    // back-to-back frames with random gaps; frame B must not see frame A's peak
    thresh = 16'd500;
    clear_frame();
    fre[7] = 900; fre[60] = 100;
    send_frame(30, 7, 900, 1);
    clear_frame();
    fre[99] = 300; fim[33] = 50;
    send_frame(30, 99, 300, 0);
    idle(10);

    // reset mid-frame discards the partial frame
    clear_frame();
    fre[2] = 5000;
    for (int k = 0; k < 100; k++) begin
      di_en = 1'b1;
      di_re = 16'(fre[br8(k)]);
      di_im = 16'(fim[br8(k)]);
      @(negedge clock);
    end
    reset = 1'b1;
    di_en = 1'b0;
    @(negedge clock);
    check("mid_rst_valid", 32'(pk_valid), 32'd0);
    check("mid_rst_bin", 32'(pk_bin), 32'd0);
    check("mid_rst_mag", 32'(pk_mag), 32'd0);
    check("mid_rst_found", 32'(pk_found), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    idle(3);
    clear_frame();
    fre[40] = 600;
    send_frame(0, 40, 600, 1);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clock);
    check("missing_pulses", 32'(sb.size()), 32'd0);
    idle(10);
    check("pulse_count", 32'(pulses), 32'd10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
